autoconfig_master: RTL and testbench
====================================

AUTOCONFIG_MASTER -- requirements
Module: autoconfig_master

Interface
REQ-001 SHALL have these parameters: BUS_IDLE, default 1, CLK cycles of idle between bus cycles; MAX_BOARDS, default 8, loop limit before error.
REQ-002 SHALL have ports: CLK  in  1  rising-edge clock; reset  in  1  asynchronous, active-low reset.
REQ-003 SHALL have ports: start  in  1  one-cycle pulse, begins a configuration scan; busy  out  1  scan in progress; done  out  1  one-cycle pulse, scan finished; error  out  1  sticky, MAX_BOARDS exceeded.
REQ-004 SHALL have ports: ADDR  out  23  bus address [23:1]; ASn/UDSn/LDSn/RWn  out  1 each  68000 strobes; DBUS_out  out  4  write nibble [15:12]; DBUS_oe  out  1  data drive enable; DBUS_in  in  4  read nibble [15:12].
REQ-005 SHALL have ports: CFGOUTn  out  1  drives first board's CFGINn; board_count  out  4  boards given a base; alloc_map  out  8  1MB slots used, bit n = $200000+n*1MB.

Function
REQ-006 Bus cycle = 6 CLKs, C0..C5. C0: ADDR/RWn/DBUS_out valid, DBUS_oe=1 for writes. C1: ASn=0, UDSn=0 on reads. C2: UDSn=0 on writes. C4: DBUS_in sampled at end of cycle. C5: ASn=UDSn=1, DBUS_oe=0. Then BUS_IDLE idle CLKs.
REQ-007 LDSn SHALL remain 1 at all times; ADDR and DBUS_out SHALL hold stable from C0 through C5.
REQ-008 FSM states: IDLE, RD_TYPE, RD_SIZE, DECIDE, WR_LO, WR_HI, WR_SHUTUP, FINISH.
REQ-009 IDLE -> RD_TYPE on start; CFGOUTn=0 and busy=1 from the cycle after start until FINISH.
REQ-010 RD_TYPE: read $E80000 (ADDR[8:1]=0x00); board present iff nibble[3:2]==2'b11 and nibble!=4'hF; absent -> FINISH.
REQ-011 RD_SIZE: read $E80002 (0x01); nibble[2:0]: 000=8MB, 111=4MB, 110=2MB, 101=1MB, 001..100 = 1MB slot.
REQ-012 DECIDE: first-fit in 1 CLK over legal slots: 8MB slot 0 only; 4MB slots 0,2,4; 2MB slots 0,2,4,6; 1MB slots 0..7; a fit requires all covered slots free in alloc_map.
REQ-013 Fit -> WR_LO: write 0x0 to 0x25 ($E8004A); then WR_HI: write base nibble = first slot + 2 to 0x24 ($E80048); then set covered alloc_map bits, increment board_count, return to RD_TYPE.
REQ-014 No fit -> WR_SHUTUP: write 0x0 to 0x26 ($E8004C), then RD_TYPE; the same board may re-offer a smaller size.
REQ-015 A loop counter SHALL count WR_HI plus WR_SHUTUP writes; reaching MAX_BOARDS*4 SHALL set error and go to FINISH.
REQ-016 FINISH: pulse done 1 CLK, busy=0, CFGOUTn=1, IDLE; alloc_map, board_count and error hold until the next start.
REQ-017 start while busy SHALL be ignored; start in IDLE SHALL clear alloc_map, board_count and error.
REQ-018 board_count SHALL saturate at 15.

Reset
REQ-019 Reset asserted SHALL immediately force state IDLE, ASn=UDSn=LDSn=RWn=1, DBUS_oe=0, DBUS_out=0, ADDR=0, CFGOUTn=1, busy=0, done=0, error=0, board_count=0, alloc_map=0, regardless of bus phase.
REQ-020 The first start after reset release SHALL begin a full scan; no bus cycle SHALL be issued without a start.

Verification
REQ-021 One responder offering 8MB -> reads 0x00=0xE, 0x01=0x0; writes 0x25=0, 0x24=2; alloc_map=0xFF, board_count=1, done pulse.
REQ-022 No board (DBUS_in pulled to 0xF) -> single read of 0x00, FINISH; board_count=0, alloc_map=0x00.
REQ-023 alloc_map preset full by prior 8MB board, second board offering 8/4/2/1MB in turn -> four 0x26 shutup writes, then absent read -> board_count=1.
REQ-024 Board A 2MB, then board B 4MB -> A base 2 (map 0x03), B base 4 (map 0x3C), board_count=2.
REQ-025 Responder always present and always refusing -> error=1 after 32 writes, done pulse, busy=0.
REQ-026 reset asserted during C2 of a write -> all strobes 1 and DBUS_oe=0 same cycle; new start reruns cleanly.

Source files
------------

// File: rtl/autoconfig_master.sv
// autoconfig_master: Zorro-II style autoconfig scanner; issues 68000-style nibble bus cycles to size, place and base boards.
// Ports: CLK, reset (async, active-low); start pulse in, busy/done/error status out;
//        ADDR[23:1], ASn/UDSn/LDSn/RWn strobes, DBUS_out/DBUS_oe/DBUS_in nibble [15:12];
//        CFGOUTn to the first board; board_count and alloc_map (bit n = 1MB slot at $200000+n*1MB).
module autoconfig_master #(
  parameter int BUS_IDLE   = 1,
  parameter int MAX_BOARDS = 8
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic        start,
  output logic        busy,
  output logic        done,
  output logic        error,
  output logic [22:0] ADDR,
  output logic        ASn,
  output logic        UDSn,
  output logic        LDSn,
  output logic        RWn,
  output logic [3:0]  DBUS_out,
  output logic        DBUS_oe,
  input  logic [3:0]  DBUS_in,
  output logic        CFGOUTn,
  output logic [3:0]  board_count,
  output logic [7:0]  alloc_map
);
  localparam int LIM = MAX_BOARDS * 4;
  localparam int LW = $clog2(LIM + 1);
  localparam logic [7:0] PLAST = 8'(5 + BUS_IDLE);
  localparam logic [LW-1:0] LLAST = LW'(LIM - 1);
  typedef enum logic [2:0] {IDLE, RD_TYPE, RD_SIZE, DECIDE, WR_LO, WR_HI, WR_SHUTUP, FINISH} state_t;
  state_t state, nxt;
  logic [7:0] ph, idx, mask, amask;
  logic [3:0] nib, base;
  logic [2:0] slot;
  logic [LW-1:0] loops;
  logic bus, wr, act, last, present, fit, hit_lim, cnt_wr;
  assign bus = state inside {RD_TYPE, RD_SIZE, WR_LO, WR_HI, WR_SHUTUP};
  assign wr = state inside {WR_LO, WR_HI, WR_SHUTUP};
  assign act = bus && ph <= 8'd5;
  assign last = bus && ph == PLAST;
  assign present = nib[3:2] == 2'b11 && nib != 4'hF;
  assign hit_lim = loops == LLAST;
  assign cnt_wr = last && (state == WR_HI || state == WR_SHUTUP);
  assign idx = state == RD_SIZE ? 8'h01 : state == WR_LO ? 8'h25 : state == WR_HI ? 8'h24 :
               state == WR_SHUTUP ? 8'h26 : 8'h00;
  assign ADDR = act ? {15'h7400, idx} : '0;
  assign ASn = !(bus && ph >= 8'd1 && ph <= 8'd4);
  assign UDSn = !(bus && ph >= (wr ? 8'd2 : 8'd1) && ph <= 8'd4);
  assign LDSn = 1'b1;
  assign RWn = !(wr && act);
  assign DBUS_oe = wr && ph <= 8'd4;
  assign DBUS_out = (state == WR_HI && act) ? base : 4'd0;
  assign busy = bus || state == DECIDE;
  assign CFGOUTn = !busy;
  assign done = state == FINISH;
  // First fit: scan slots high to low so the lowest legal free slot wins.
  // Multi-MB boards sit on even slots; the s+n bound keeps 8MB at slot 0 and 4MB at 0/2/4.
  always_comb begin
    int n;
    logic [7:0] m;
    n = nib[2:0] == 3'd0 ? 8 : nib[2:0] == 3'd7 ? 4 : nib[2:0] == 3'd6 ? 2 : 1;
    fit = 1'b0;
    slot = 3'd0;
    mask = 8'd0;
    for (int s = 7; s >= 0; s--) begin
      m = 8'(((1 << n) - 1) << s);
      if ((n == 1 || s % 2 == 0) && s + n <= 8 && (alloc_map & m) == 8'd0) begin
        fit = 1'b1;
        slot = 3'(s);
        mask = m;
      end
    end
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:              nxt = start ? RD_TYPE : IDLE;
      RD_TYPE:           nxt = last ? (present ? RD_SIZE : FINISH) : RD_TYPE;
      RD_SIZE:           nxt = last ? DECIDE : RD_SIZE;
      DECIDE:            nxt = fit ? WR_LO : WR_SHUTUP;
      WR_LO:             nxt = last ? WR_HI : WR_LO;
      WR_HI, WR_SHUTUP:  nxt = last ? (hit_lim ? FINISH : RD_TYPE) : state;
      FINISH:            nxt = IDLE;
      default:           nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or negedge reset)
    if (!reset) state <= IDLE;
    else state <= nxt;
  always_ff @(posedge CLK or negedge reset) begin
    if (!reset) begin
      ph <= 8'd0;
      nib <= 4'd0;
      base <= 4'd0;
      amask <= 8'd0;
      loops <= '0;
      alloc_map <= 8'd0;
      board_count <= 4'd0;
      error <= 1'b0;
    end else begin
      ph <= (bus && !last) ? ph + 8'd1 : 8'd0;
      if (bus && !wr && ph == 8'd4) nib <= DBUS_in;
      if (state == DECIDE) begin
        base <= {1'b0, slot} + 4'd2;
        amask <= mask;
      end
      if (state == IDLE && start) begin
        alloc_map <= 8'd0;
        board_count <= 4'd0;
        error <= 1'b0;
        loops <= '0;
      end
      if (cnt_wr) begin
        loops <= loops + LW'(1);
        error <= error | hit_lim;
      end
      if (last && state == WR_HI) begin
        alloc_map <= alloc_map | amask;
        board_count <= board_count + {3'd0, board_count != 4'hF};
      end
    end
  end
endmodule

// File: tb/tb_autoconfig_master.sv
// tb_autoconfig_master: directed scenario table plus hand sequences against a behavioural board-chain responder.
module tb_autoconfig_master;
  logic CLK = 1'b0, reset = 1'b0, start = 1'b0;
  logic [22:0] ADDR;
  logic ASn, UDSn, LDSn, RWn, DBUS_oe, CFGOUTn, busy, done, error;
  logic [3:0] DBUS_out, DBUS_in, board_count;
  logic [7:0] alloc_map;
  always #5 CLK = ~CLK;
  autoconfig_master dut (
    .CLK(CLK), .reset(reset), .start(start), .busy(busy), .done(done), .error(error),
    .ADDR(ADDR), .ASn(ASn), .UDSn(UDSn), .LDSn(LDSn), .RWn(RWn), .DBUS_out(DBUS_out),
    .DBUS_oe(DBUS_oe), .DBUS_in(DBUS_in), .CFGOUTn(CFGOUTn), .board_count(board_count),
    .alloc_map(alloc_map)
  );
  // Board chain: nb boards, each offering sizes (nibble k = k-th offer) in turn; fv = never goes away.
  typedef struct packed {
    logic [1:0]  nb;
    logic [15:0] ca;
    logic [2:0]  na;
    logic [15:0] cb;
    logic [2:0]  nbo;
    logic        fv;
    logic [3:0]  cnt;
    logic [7:0]  map;
    logic        err;
    logic [6:0]  nw;
    logic [6:0]  nr;
    logic [71:0] w;
  } vec_t;
  vec_t vecs[7];
  vec_t cv;
  int checks = 0, errors = 0, prot_bad = 0;
  int rb = 0, ro = 0, nw = 0, nr = 0, run_id = 0, seen = 0;
  logic [11:0] wlog[64];
  logic pu = 1'b1, pas = 1'b1;
  logic [22:0] pa = '0;
  logic [3:0] pd = '0;
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s got %0h want %0h", name, act, exp);
    end
  endtask
  always_comb begin
    logic pr;
    pr = cv.fv || rb < int'(cv.nb);
    DBUS_in = ADDR[7:0] == 8'h00 ? (pr ? 4'hE : 4'hF) :
              (ADDR[7:0] == 8'h01 && pr) ? (rb == 0 ? cv.ca[ro*4 +: 4] : cv.cb[ro*4 +: 4]) : 4'hF;
  end
  always @(negedge CLK) begin
    if (seen != run_id) begin
      seen = run_id;
      rb = 0;
      ro = 0;
      nw = 0;
      nr = 0;
    end
    if (reset) begin
      if (LDSn !== 1'b1 || (!UDSn && ASn) || (!ASn && ADDR[22:8] != 15'h7400) ||
          (!ASn && !pas && (ADDR != pa || DBUS_out != pd))) begin
        prot_bad++;
        $display("protocol violation at %0t: ADDR=%0h ASn=%b UDSn=%b LDSn=%b", $time, ADDR, ASn, UDSn, LDSn);
      end
      if (!UDSn && pu) begin
        if (!RWn) begin
          if (nw < 64) wlog[nw] = {ADDR[7:0], DBUS_out};
          nw++;
          if (!cv.fv) begin
            if (ADDR[7:0] == 8'h24) begin
              rb++;
              ro = 0;
            end else if (ADDR[7:0] == 8'h26) begin
              ro++;
              if (ro == (rb == 0 ? int'(cv.na) : int'(cv.nbo))) begin
                rb++;
                ro = 0;
              end
            end
          end
        end else nr++;
      end
    end
    pu = UDSn;
    pas = ASn;
    pa = ADDR;
    pd = DBUS_out;
  end
  task automatic kick(input int i);
    cv = vecs[i];
    run_id++;
    @(negedge CLK);
    start = 1'b1;
    @(negedge CLK);
    start = 1'b0;
  endtask
  task automatic wait_done(input string name);
    int k = 0;
    while (!done && k < 5000) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_done"}, 32'(done), 32'd1);
  endtask
  task automatic wait_write(input string name);
    int k = 0;
    while (RWn && k < 500) begin
      @(negedge CLK);
      k++;
    end
    chk({name, "_wr_seen"}, 32'(RWn), 32'd0);
  endtask
  task automatic run_vec(input int i, input bit poke);
    kick(i);
    chk($sformatf("v%0d_busy", i), 32'({busy, CFGOUTn}), 32'h2);
    if (poke) begin
      repeat (20) @(negedge CLK);
      start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
    end
    wait_done($sformatf("v%0d", i));
    chk($sformatf("v%0d_count", i), 32'(board_count), 32'(cv.cnt));
    chk($sformatf("v%0d_map", i), 32'(alloc_map), 32'(cv.map));
    chk($sformatf("v%0d_error", i), 32'(error), 32'(cv.err));
    chk($sformatf("v%0d_nwrites", i), 32'(nw), 32'(cv.nw));
    chk($sformatf("v%0d_nreads", i), 32'(nr), 32'(cv.nr));
    for (int k = 0; k < 6 && k < int'(cv.nw); k++)
      chk($sformatf("v%0d_write%0d", i, k), 32'(wlog[k]), 32'(cv.w[12*k +: 12]));
    @(negedge CLK);
    chk($sformatf("v%0d_post", i), 32'({done, busy, CFGOUTn}), 32'h1);
    repeat (3) @(negedge CLK);
    chk($sformatf("v%0d_hold", i), 32'({error, board_count, alloc_map}), 32'({cv.err, cv.cnt, cv.map}));
  endtask
  task automatic check_timing();
    logic [27:0] rt, wt;
    rt = 28'hE2222EE;
    wt = 28'hD5111CE;
    kick(0);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("rd_c%0d", k), 32'({ASn, UDSn, RWn, DBUS_oe}), 32'(rt[4*(6-k) +: 4]));
      if (k == 1) chk("rd_addr", 32'(ADDR), 32'h740000);
      @(negedge CLK);
    end
    wait_write("tim");
    chk("wr_addr", 32'(ADDR), 32'h740025);
    for (int k = 0; k < 7; k++) begin
      chk($sformatf("wr_c%0d", k), 32'({ASn, UDSn, RWn, DBUS_oe}), 32'(wt[4*(6-k) +: 4]));
      @(negedge CLK);
    end
    wait_done("tim");
    @(negedge CLK);
  endtask
  task automatic reset_mid_write();
    kick(0);
    wait_write("rst");
    repeat (2) @(negedge CLK);
    chk("rst_c2", 32'({ASn, UDSn, RWn}), 32'h0);
    reset = 1'b0;
    #1;
    chk("rst_mid_strobes", 32'({ASn, UDSn, LDSn, RWn, DBUS_oe}), 32'h1E);
    chk("rst_mid_bus", 32'({ADDR, DBUS_out}), 32'h0);
    chk("rst_mid_status", 32'({busy, done, error, CFGOUTn, board_count, alloc_map}), 32'h1000);
    @(negedge CLK);
    reset = 1'b1;
  endtask
  initial begin
    vecs[0] = '{2'd1, 16'h0000, 3'd1, 16'h0000, 3'd0, 1'b0, 4'd1, 8'hFF, 1'b0, 7'd2, 7'd3,
                {12'h0, 12'h0, 12'h0, 12'h0, 12'h242, 12'h250}};
    vecs[1] = '{2'd0, 16'h0000, 3'd0, 16'h0000, 3'd0, 1'b0, 4'd0, 8'h00, 1'b0, 7'd0, 7'd1, 72'h0};
    vecs[2] = '{2'd2, 16'h0000, 3'd1, 16'h5670, 3'd4, 1'b0, 4'd1, 8'hFF, 1'b0, 7'd6, 7'd11,
                {12'h260, 12'h260, 12'h260, 12'h260, 12'h242, 12'h250}};
    vecs[3] = '{2'd2, 16'h0006, 3'd1, 16'h0007, 3'd1, 1'b0, 4'd2, 8'h3F, 1'b0, 7'd4, 7'd5,
                {12'h0, 12'h0, 12'h244, 12'h250, 12'h242, 12'h250}};
    vecs[4] = '{2'd1, 16'h0000, 3'd1, 16'h0000, 3'd0, 1'b1, 4'd1, 8'hFF, 1'b1, 7'd33, 7'd64,
                {12'h260, 12'h260, 12'h260, 12'h260, 12'h242, 12'h250}};
    vecs[5] = '{2'd2, 16'h0003, 3'd1, 16'h0005, 3'd1, 1'b0, 4'd2, 8'h03, 1'b0, 7'd4, 7'd5,
                {12'h0, 12'h0, 12'h243, 12'h250, 12'h242, 12'h250}};
    vecs[6] = '{2'd2, 16'h0006, 3'd1, 16'h0000, 3'd1, 1'b0, 4'd1, 8'h03, 1'b0, 7'd3, 7'd5,
                {12'h0, 12'h0, 12'h0, 12'h260, 12'h242, 12'h250}};
    cv = vecs[1];
    repeat (3) @(negedge CLK);
    chk("rst_strobes", 32'({ASn, UDSn, LDSn, RWn, DBUS_oe}), 32'h1E);
    chk("rst_status", 32'({busy, done, error, CFGOUTn}), 32'h1);
    chk("rst_bus", 32'({ADDR, DBUS_out}), 32'h0);
    chk("rst_result", 32'({board_count, alloc_map}), 32'h0);
    reset = 1'b1;
    repeat (20) @(negedge CLK);
    chk("no_bus", 32'(nr + nw), 32'd0);
    check_timing();
    for (int i = 0; i < 7; i++) run_vec(i, i == 3);
    reset_mid_write();
    repeat (20) @(negedge CLK);
    chk("no_bus_after_rst", 32'({busy, ASn}), 32'h1);
    run_vec(0, 1'b0);
    chk("protocol", 32'(prot_bad), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
